// File: rtl/traceback_decoder.sv
// Converts a traceback coordinate stream into alignment ops (match/mismatch/gap) with op counters.
// Define TRACEBACK_SCORE_EN to add a running alignment-score accumulator; otherwise score is tied to 0.
module traceback_decoder #(
   parameter int LENGTH      = 10,
   parameter int CWIDTH      = 2,
   parameter int SWIDTH      = 16,
   parameter int CORD_LENGTH = 8,
   parameter int MATCH       = 1,
   parameter int MISMATCH    = -1,
   parameter int INDEL       = -1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [LENGTH*CWIDTH-1:0]    s1,
   input  logic [LENGTH*CWIDTH-1:0]    s2,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2*CORD_LENGTH-1:0]    in_coord,
   output logic                        op_valid,
   input  logic                        op_ready,
   output logic [1:0]                  op_code,
   output logic [CWIDTH-1:0]           op_c1,
   output logic [CWIDTH-1:0]           op_c2,
   output logic [CORD_LENGTH:0]        n_match,
   output logic [CORD_LENGTH:0]        n_mismatch,
   output logic [CORD_LENGTH:0]        n_indel,
   output logic signed [SWIDTH-1:0]    score,
   output logic                        done,
   output logic                        error
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_FLUSH,
      ST_DONE,
      ST_ERROR
   } state_e;

   typedef enum logic [1:0] {
      OP_MATCH    = 2'b00,
      OP_MISMATCH = 2'b01,
      OP_GAP_S2   = 2'b10,
      OP_GAP_S1   = 2'b11
   } op_e;

   localparam logic [CORD_LENGTH-1:0] LEN_C  = CORD_LENGTH'(LENGTH);
   localparam logic [CORD_LENGTH-1:0] LAST_C = CORD_LENGTH'(LENGTH - 1);
   localparam logic [CORD_LENGTH-1:0] ONE_C  = CORD_LENGTH'(1);

   state_e state, next_state;

   logic [CORD_LENGTH-1:0] cx, cy, hx, hy, dx, dy;
   logic                   in_range, step_diag, step_top, step_left, step_ok;
   logic                   out_free, accept, new_is_origin;
   logic [CWIDTH-1:0]      held_c1, held_c2;
   logic                   load;
   op_e                    load_code;
   logic [CWIDTH-1:0]      load_c1, load_c2;

   // Constant-index character lookup keeps the select free of variable-width indexing.
   function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                 input logic [CORD_LENGTH-1:0] idx);
      char_at = '0;
      for (int i = 0; i < LENGTH; i++) begin
         if (idx == CORD_LENGTH'(i)) char_at = s[i*CWIDTH +: CWIDTH];
      end
   endfunction

   assign cx            = in_coord[CORD_LENGTH-1:0];
   assign cy            = in_coord[2*CORD_LENGTH-1:CORD_LENGTH];
   assign dx            = hx - cx;
   assign dy            = hy - cy;
   assign in_range      = (cx < LEN_C) && (cy < LEN_C);
   assign step_diag     = (dx == ONE_C) && (dy == ONE_C);
   assign step_top      = (dx == '0)    && (dy == ONE_C);
   assign step_left     = (dx == ONE_C) && (dy == '0);
   assign step_ok       = in_range && (step_diag || step_top || step_left);
   assign new_is_origin = (cx == '0) && (cy == '0);
   assign held_c1       = char_at(s1, hy);
   assign held_c2       = char_at(s2, hx);

   // The output register is free when empty or being drained this cycle.
   assign out_free = !op_valid || op_ready;
   assign in_ready = !reset && ((state == ST_IDLE) || ((state == ST_HOLD) && out_free));
   assign accept   = in_valid && in_ready;
   assign error    = (state == ST_ERROR);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state and op-load decision; every op describes the held coord, never the new one.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_code  = OP_MATCH;
      load_c1    = '0;
      load_c2    = '0;
      case (state)
         ST_IDLE: begin
            if (accept) next_state = ((cx == LAST_C) && (cy == LAST_C)) ? ST_HOLD : ST_ERROR;
         end
         ST_HOLD: begin
            if (accept) begin
               if (!step_ok) begin
                  next_state = ST_ERROR;
               end else begin
                  load = 1'b1;
                  if (step_top) begin
                     load_code = OP_GAP_S2;
                     load_c1   = held_c1;
                  end else if (step_left) begin
                     load_code = OP_GAP_S1;
                     load_c2   = held_c2;
                  end else begin
                     load_code = (held_c1 == held_c2) ? OP_MATCH : OP_MISMATCH;
                     load_c1   = held_c1;
                     load_c2   = held_c2;
                  end
                  if (new_is_origin) next_state = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (out_free) begin
               load       = 1'b1;
               load_code  = (held_c1 == held_c2) ? OP_MATCH : OP_MISMATCH;
               load_c1    = held_c1;
               load_c2    = held_c2;
               next_state = ST_DONE;
            end
         end
         default: ;
      endcase
   end

   // Held coord tracks every legally accepted coordinate.
   always_ff @(posedge clk) begin
      if (reset) begin
         hx <= '0;
         hy <= '0;
      end else if (accept && (next_state != ST_ERROR)) begin
         hx <= cx;
         hy <= cy;
      end
   end

   // Output register, op counters and the sticky done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_valid   <= 1'b0;
         op_code    <= '0;
         op_c1      <= '0;
         op_c2      <= '0;
         n_match    <= '0;
         n_mismatch <= '0;
         n_indel    <= '0;
         done       <= 1'b0;
      end else begin
         if (load) begin
            op_valid <= 1'b1;
            op_code  <= load_code;
            op_c1    <= load_c1;
            op_c2    <= load_c2;
            case (load_code)
               OP_MATCH:    n_match    <= n_match + 1'b1;
               OP_MISMATCH: n_mismatch <= n_mismatch + 1'b1;
               default:     n_indel    <= n_indel + 1'b1;
            endcase
         end else if ((next_state == ST_ERROR) || op_ready) begin
            op_valid <= 1'b0;
         end
         if ((state == ST_DONE) && out_free) done <= 1'b1;
      end
   end

`ifdef TRACEBACK_SCORE_EN
   logic signed [SWIDTH-1:0] score_acc;
   logic signed [SWIDTH-1:0] weight;

   always_comb begin
      weight = SWIDTH'(INDEL);
      case (load_code)
         OP_MATCH:    weight = SWIDTH'(MATCH);
         OP_MISMATCH: weight = SWIDTH'(MISMATCH);
         default:     weight = SWIDTH'(INDEL);
      endcase
   end

   // Wraps modulo 2^SWIDTH by construction.
   always_ff @(posedge clk) begin
      if (reset)     score_acc <= '0;
      else if (load) score_acc <= score_acc + weight;
   end

   assign score = score_acc;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_traceback_decoder.sv
// Scoreboard bench for traceback_decoder (LENGTH=4): a path-level model predicts the op stream,
// a monitor pops and compares every transferred op independently of the stimulus.
module tb_traceback_decoder;

   localparam int LEN = 4;
   localparam int CW  = 2;
   localparam int CL  = 8;

   localparam int OP_MATCH    = 0;
   localparam int OP_MISMATCH = 1;
   localparam int OP_GAP_S2   = 2;
   localparam int OP_GAP_S1   = 3;

   typedef struct {
      int code;
      int c1;
      int c2;
   } op_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [LEN*CW-1:0]     s1, s2;
   logic                  in_valid;
   logic                  in_ready;
   logic [2*CL-1:0]       in_coord;
   logic                  op_valid;
   logic                  op_ready;
   logic [1:0]            op_code;
   logic [CW-1:0]         op_c1, op_c2;
   logic [CL:0]           n_match, n_mismatch, n_indel;
   logic signed [15:0]    score;
   logic                  done;
   logic                  error;

   op_t expected_q[$];
   int  path_x[$];
   int  path_y[$];
   int  checks   = 0;
   int  failures = 0;
   int  exp_match, exp_mismatch, exp_indel, exp_score;
   bit  ready_random = 1'b0;
   bit  ready_hold   = 1'b0;

   traceback_decoder #(
      .LENGTH(LEN), .CWIDTH(CW), .SWIDTH(16), .CORD_LENGTH(CL)
   ) dut (
      .clk(clk), .reset(reset), .s1(s1), .s2(s2),
      .in_valid(in_valid), .in_ready(in_ready), .in_coord(in_coord),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_c1(op_c1), .op_c2(op_c2),
      .n_match(n_match), .n_mismatch(n_mismatch), .n_indel(n_indel),
      .score(score), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual != required) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
      end
   endtask

   // Reference: characters by arithmetic, op chosen from the step leaving the held coord.
   function automatic int char_of(input int s, input int i);
      return (s >> (CW * i)) & 3;
   endfunction

   function automatic op_t model_op(input int s1v, input int s2v, input int hx, input int hy,
                                    input int dx, input int dy);
      op_t o;
      int  a = char_of(s1v, hy);
      int  b = char_of(s2v, hx);
      if (dx == 1 && dy == 1) begin
         o.code = (a == b) ? OP_MATCH : OP_MISMATCH;
         o.c1 = a;
         o.c2 = b;
      end else if (dx == 0 && dy == 1) begin
         o.code = OP_GAP_S2;
         o.c1 = a;
         o.c2 = 0;
      end else begin
         o.code = OP_GAP_S1;
         o.c1 = 0;
         o.c2 = b;
      end
      return o;
   endfunction

   task automatic buildExpected(input int s1v, input int s2v);
      op_t o;
      exp_match = 0; exp_mismatch = 0; exp_indel = 0; exp_score = 0;
      for (int i = 0; i < path_x.size(); i++) begin
         if (i == path_x.size() - 1) o = model_op(s1v, s2v, path_x[i], path_y[i], 1, 1);
         else o = model_op(s1v, s2v, path_x[i], path_y[i],
                           path_x[i] - path_x[i+1], path_y[i] - path_y[i+1]);
         expected_q.push_back(o);
         if (o.code == OP_MATCH) begin
            exp_match++; exp_score += 1;
         end else if (o.code == OP_MISMATCH) begin
            exp_mismatch++; exp_score -= 1;
         end else begin
            exp_indel++; exp_score -= 1;
         end
      end
   endtask

   task automatic makeRandomPath();
      int x = LEN - 1;
      int y = LEN - 1;
      int c;
      path_x.delete(); path_y.delete();
      path_x.push_back(x); path_y.push_back(y);
      while (x > 0 || y > 0) begin
         c = $urandom_range(0, 2);
         if (x > 0 && y > 0 && c == 0) begin
            x--; y--;
         end else if (y > 0 && (c == 1 || x == 0)) y--;
         else if (x > 0) x--;
         else y--;
         path_x.push_back(x); path_y.push_back(y);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the coordinate is accepted.
   task automatic sendCoord(input int x, input int y);
      int n = 0;
      in_valid = 1'b1;
      in_coord = {CL'(y), CL'(x)};
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("coord_accept_timeout", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < path_x.size(); i++) sendCoord(path_x[i], path_y[i]);
   endtask

   task automatic applyReset();
      @(posedge clk); #1;
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_during_reset", int'(in_ready), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("rst_op_valid", int'(op_valid), 0);
      checkOutput("rst_op_code", int'(op_code), 0);
      checkOutput("rst_op_c1", int'(op_c1), 0);
      checkOutput("rst_op_c2", int'(op_c2), 0);
      checkOutput("rst_n_match", int'(n_match), 0);
      checkOutput("rst_n_mismatch", int'(n_mismatch), 0);
      checkOutput("rst_n_indel", int'(n_indel), 0);
      checkOutput("rst_score", int'(score), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_error", int'(error), 0);
      expected_q.delete();
   endtask

   task automatic waitDone();
      int n = 0;
      while (done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done", int'(done), 1);
      checkOutput("ops_outstanding", expected_q.size(), 0);
      checkOutput("final_op_valid", int'(op_valid), 0);
      checkOutput("final_in_ready", int'(in_ready), 0);
      checkOutput("final_error", int'(error), 0);
      checkOutput("n_match", int'(n_match), exp_match);
      checkOutput("n_mismatch", int'(n_mismatch), exp_mismatch);
      checkOutput("n_indel", int'(n_indel), exp_indel);
`ifdef TRACEBACK_SCORE_EN
      checkOutput("score", int'(score), exp_score);
`else
      checkOutput("score", int'(score), 0);
`endif
   endtask

   task automatic runPath(input int s1v, input int s2v);
      applyReset();
      s1 = (LEN*CW)'(s1v);
      s2 = (LEN*CW)'(s2v);
      buildExpected(s1v, s2v);
      applyStimulus();
      waitDone();
   endtask

   // Output handshake driver: always ready, or randomly throttled.
   initial begin
      op_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!ready_hold) op_ready = ready_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor: pops on each transfer and checks stability while stalled.
   initial begin
      op_t e;
      bit  stalled = 1'b0;
      int  s_code, s_c1, s_c2;
      forever begin
         @(negedge clk);
         if (!reset && op_valid && op_ready) begin
            if (expected_q.size() == 0) begin
               checkOutput("op_without_expectation", int'(op_valid), 0);
            end else begin
               e = expected_q.pop_front();
               checkOutput("op_code", int'(op_code), e.code);
               checkOutput("op_c1", int'(op_c1), e.c1);
               checkOutput("op_c2", int'(op_c2), e.c2);
            end
         end
         if (!reset && op_valid && !op_ready) begin
            if (stalled) begin
               checkOutput("stall_op_code", int'(op_code), s_code);
               checkOutput("stall_op_c1", int'(op_c1), s_c1);
               checkOutput("stall_op_c2", int'(op_c2), s_c2);
            end
            stalled = 1'b1;
            s_code = int'(op_code); s_c1 = int'(op_c1); s_c2 = int'(op_c2);
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_coord = '0;
      s1 = '0;
      s2 = '0;
      repeat (2) @(posedge clk);

      $display("[TB] all-match diagonal path");
      path_x = '{3, 2, 1, 0}; path_y = '{3, 2, 1, 0};
      runPath(8'hE4, 8'hE4);

      $display("[TB] gap path");
      path_x = '{3, 3, 2, 1, 0}; path_y = '{3, 2, 1, 0, 0};
      runPath(8'h1B, 8'hE4);

      $display("[TB] output stall");
      applyReset();
      s1 = 8'h9C; s2 = 8'h9C;
      path_x = '{3, 2, 1, 0}; path_y = '{3, 2, 1, 0};
      buildExpected(8'h9C, 8'h9C);
      fork
         applyStimulus();
         begin
            int n = 0;
            while (!op_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            checkOutput("first_op_seen", int'(op_valid), 1);
            ready_hold = 1'b1;
            @(posedge clk); #1;
            op_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               checkOutput("stall_in_ready", int'(in_ready), 0);
               checkOutput("stall_op_valid", int'(op_valid), 1);
            end
            @(posedge clk); #1;
            op_ready = 1'b1;
            ready_hold = 1'b0;
         end
      join
      waitDone();

      $display("[TB] illegal step");
      applyReset();
      sendCoord(3, 3);
      sendCoord(1, 1);
      checkOutput("bad_step_error", int'(error), 1);
      checkOutput("bad_step_op_valid", int'(op_valid), 0);
      checkOutput("bad_step_in_ready", int'(in_ready), 0);
      in_valid = 1'b1;
      in_coord = {8'd2, 8'd2};
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("error_sticky", int'(error), 1);
      checkOutput("error_counters_frozen", int'(n_match + n_mismatch + n_indel), 0);

      $display("[TB] illegal first coordinate");
      applyReset();
      sendCoord(2, 3);
      checkOutput("bad_start_error", int'(error), 1);
      checkOutput("bad_start_in_ready", int'(in_ready), 0);

      $display("[TB] reset mid-sequence");
      applyReset();
      s1 = 8'hE4; s2 = 8'hE4;
      expected_q.push_back(model_op(32'hE4, 32'hE4, 3, 3, 1, 1));
      sendCoord(3, 3);
      sendCoord(2, 2);
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_queue_drained", expected_q.size(), 0);
      path_x = '{3, 2, 1, 0}; path_y = '{3, 2, 1, 0};
      runPath(8'hE4, 8'hE4);

      $display("[TB] randomized paths");
      for (int t = 0; t < 24; t++) begin
         ready_random = t[0];
         makeRandomPath();
         runPath(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      ready_random = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
